decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode pipeline stage of the RV32I core; sits between fetch and execute.
- Drives the register file read addresses (address_a_in/address_b_in of register_file) from the incoming instruction and consumes reg_a_out/reg_b_out combinationally.
- Bypasses same-cycle writeback data, generates immediates, detects load-use hazards, and registers one decoded instruction for execute behind a valid/ready handshake.

Parameters:
XLEN, 32, datapath/PC width.
REG_ADDR_W, 5, register index width (32 architectural registers, x0 hardwired zero).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
if_valid_in  input  1  fetch presents an instruction
if_instr_in  input  32  instruction word
if_pc_in  input  XLEN  PC of if_instr_in
if_ready_out  output  1  stage accepts the instruction this cycle
rf_addr_a_out  output  REG_ADDR_W  rs1 index = if_instr_in[19:15], combinational
rf_addr_b_out  output  REG_ADDR_W  rs2 index = if_instr_in[24:20], combinational
rf_a_in  input  XLEN  register_file reg_a_out (combinational read)
rf_b_in  input  XLEN  register_file reg_b_out
wb_write_in  input  1  writeback writes the register file this cycle (same signal as rf_write_in)
wb_addr_in  input  REG_ADDR_W  writeback destination (address_c_in)
wb_data_in  input  XLEN  writeback data (data_in)
flush_in  input  1  discard the held instruction and any transfer this cycle
ex_ready_in  input  1  execute accepts id_* this cycle
id_valid_out  output  1  id_* fields hold a valid instruction
id_pc_out  output  XLEN  PC of held instruction
id_opcode_out  output  7  instr[6:0]
id_funct3_out  output  3  instr[14:12]
id_funct7_out  output  7  instr[31:25]
id_rd_out  output  REG_ADDR_W  instr[11:7]
id_rs1_val_out  output  XLEN  rs1 operand after bypass
id_rs2_val_out  output  XLEN  rs2 operand after bypass
id_imm_out  output  XLEN  sign-extended immediate

Behaviour:
- Reset: every id_* output is 0; the stage is empty. Reset overrides flush_in and all other inputs.
- Latency: 1 cycle. An instruction accepted at edge N appears on id_* after edge N.
- Transfer: occurs when if_valid_in && if_ready_out.
- if_ready_out = (!id_valid_out || ex_ready_in) && !hazard.
- States:
  - EMPTY: id_valid_out = 0.
  - FULL: valid instruction held.
  - HOLD: FULL with ex_ready_in = 0. All id_* stay stable, except the bypass refresh below.
- Transitions:
  - A transfer moves the stage to FULL.
  - ex_ready_in = 1 without a transfer moves the stage to EMPTY.
  - In the hazard cycle a bubble loads: id_valid_out = 0, fields don't-care but held.
- Operand select (at capture):
  - If rs = 0, the value is 0.
  - Else if wb_write_in && wb_addr_in == rs, the value is wb_data_in.
  - Else it is rf_a_in / rf_b_in.
- Writeback to x0 is never bypassed.
- HOLD refresh: if wb_write_in && wb_addr_in == held rs (nonzero), the held operand updates to wb_data_in. The held rs indices are stored internally.
- Operand usage:
  - rs1 is used by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is used only by R (0110011), S (0100011) and B (1100011).
- Load-use hazard: asserted when all of the following hold:
  - id_valid_out is set;
  - id_opcode_out = 0000011;
  - id_rd_out != 0;
  - id_rd_out matches a used rs of a valid incoming instruction.
- Hazard cycle: if_ready_out = 0. If ex_ready_in = 1, a bubble is loaded; otherwise the stage holds. After the bubble the hazard clears and the instruction is accepted next cycle, giving exactly one bubble.
- Immediates:
  - I-type (0010011, 0000011, 1100111): instr[31:20], sign-extended.
  - S-type: {instr[31:25], instr[11:7]}, sign-extended.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - R-type and other opcodes: 0.
- flush_in:
  - id_valid_out = 0 after the edge.
  - Any transfer in the same cycle is dropped; if_ready_out is not forced low.
  - The hazard is ignored during flush.
- Simultaneous ex_ready_in && transfer: execute takes the old instruction, and the new one loads in the same edge.

Test Plan:
- Assert reset for 2 cycles with if_valid_in = 1 -> all id_* = 0 and no capture; after release, 0xFFF00293 (addi x5,x0,-1) yields id_rd = 5, id_imm = 0xFFFFFFFF, id_rs1_val = 0 one cycle later.
- RF x10 = 0x00000000; wb_write = 1, wb_addr = 10, wb_data = 0xFFFFFFAA in the same cycle as an instruction with rs1 = 10, rs2 = 17 (x17 = 0xACF2255B) -> id_rs1_val = 0xFFFFFFAA, id_rs2_val = 0xACF2255B.
- Load-use: 0x0082A303 (lw x6,8(x5)) followed by 0x005303B3 (add x7,x6,x5) with ex_ready = 1 -> if_ready low for 1 cycle; sequence id_valid = 1 (lw, imm = 8), 0 (bubble), 1 (add, rd = 7).
- ex_ready = 0 for 3 cycles while FULL -> id_* stable, if_ready = 0; wb writing held rs2 = 0xCCCCCCCC during the hold -> id_rs2_val becomes 0xCCCCCCCC.
- flush_in with FULL stage and concurrent transfer -> id_valid = 0 next cycle, the transferred instruction never appears.
- S/B/U/J immediate checks:
  - 0xFE512E23 (sw x5,-4(x2)) -> imm 0xFFFFFFFC.
  - 0x000012B7 (lui) -> imm 0x00001000.
  - 0x0100006F (jal +16) -> imm 0x00000010.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I instruction-decode pipeline stage
//
// Decodes the fetched instruction, reads its source registers, bypasses a
// same-cycle writeback, builds the immediate and holds one decoded
// instruction for execute behind a valid/ready handshake. A load followed by
// a dependent instruction costs exactly one bubble.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   if_valid_in/if_ready_out/if_instr_in/if_pc_in   fetch handshake and payload
//   rf_addr_a_out/rf_addr_b_out  rs1/rs2 indices to the register file (comb)
//   rf_a_in/rf_b_in         register file read data (comb)
//   wb_write_in/wb_addr_in/wb_data_in  writeback port, bypassed into operands
//   flush_in                drop the held instruction and any transfer
//   ex_ready_in             execute consumes id_* this cycle
//   id_*                    registered decoded instruction for execute
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid_in,
  input  logic [31:0]           if_instr_in,
  input  logic [XLEN-1:0]       if_pc_in,
  output logic                  if_ready_out,
  output logic [REG_ADDR_W-1:0] rf_addr_a_out,
  output logic [REG_ADDR_W-1:0] rf_addr_b_out,
  input  logic [XLEN-1:0]       rf_a_in,
  input  logic [XLEN-1:0]       rf_b_in,
  input  logic                  wb_write_in,
  input  logic [REG_ADDR_W-1:0] wb_addr_in,
  input  logic [XLEN-1:0]       wb_data_in,
  input  logic                  flush_in,
  input  logic                  ex_ready_in,
  output logic                  id_valid_out,
  output logic [XLEN-1:0]       id_pc_out,
  output logic [6:0]            id_opcode_out,
  output logic [2:0]            id_funct3_out,
  output logic [6:0]            id_funct7_out,
  output logic [REG_ADDR_W-1:0] id_rd_out,
  output logic [XLEN-1:0]       id_rs1_val_out,
  output logic [XLEN-1:0]       id_rs2_val_out,
  output logic [XLEN-1:0]       id_imm_out
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [6:0]            opcode_q, opcode_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [6:0]            funct7_q, funct7_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0]       rs1_val_q, rs1_val_d;
  logic [XLEN-1:0]       rs2_val_q, rs2_val_d;
  logic [XLEN-1:0]       imm_q, imm_d;

  logic [6:0]            in_opcode;
  logic [REG_ADDR_W-1:0] in_rd, in_rs1, in_rs2;
  logic                  in_uses_rs1, in_uses_rs2;
  logic [XLEN-1:0]       in_rs1_val, in_rs2_val;
  logic [31:0]           in_imm32;
  logic                  hazard, transfer;

  assign in_opcode = if_instr_in[6:0];
  assign in_rd     = if_instr_in[7 +: REG_ADDR_W];
  assign in_rs1    = if_instr_in[15 +: REG_ADDR_W];
  assign in_rs2    = if_instr_in[20 +: REG_ADDR_W];

  assign rf_addr_a_out = in_rs1;
  assign rf_addr_b_out = in_rs2;

  assign in_uses_rs1 = !(in_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign in_uses_rs2 = in_opcode inside {OP_REG, OP_STORE, OP_BRANCH};

  // Load result is not available until after execute, so a consumer of the
  // load's rd right behind it must wait one cycle. Flush makes it moot.
  assign hazard = !flush_in && valid_q && (opcode_q == OP_LOAD) && (rd_q != '0) &&
                  if_valid_in &&
                  ((in_uses_rs1 && (in_rs1 == rd_q)) || (in_uses_rs2 && (in_rs2 == rd_q)));

  assign if_ready_out = (!valid_q || ex_ready_in) && !hazard;
  assign transfer     = if_valid_in && if_ready_out;

  // Register file reads the old value in the writeback cycle; bypass it.
  always_comb begin
    if (in_rs1 == '0)                                in_rs1_val = '0;
    else if (wb_write_in && (wb_addr_in == in_rs1))  in_rs1_val = wb_data_in;
    else                                             in_rs1_val = rf_a_in;
  end

  always_comb begin
    if (in_rs2 == '0)                                in_rs2_val = '0;
    else if (wb_write_in && (wb_addr_in == in_rs2))  in_rs2_val = wb_data_in;
    else                                             in_rs2_val = rf_b_in;
  end

  always_comb begin
    in_imm32 = 32'h0;
    case (in_opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        in_imm32 = {{20{if_instr_in[31]}}, if_instr_in[31:20]};
      OP_STORE:
        in_imm32 = {{20{if_instr_in[31]}}, if_instr_in[31:25], if_instr_in[11:7]};
      OP_BRANCH:
        in_imm32 = {{19{if_instr_in[31]}}, if_instr_in[31], if_instr_in[7],
                    if_instr_in[30:25], if_instr_in[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        in_imm32 = {if_instr_in[31:12], 12'h000};
      OP_JAL:
        in_imm32 = {{11{if_instr_in[31]}}, if_instr_in[31], if_instr_in[19:12],
                    if_instr_in[20], if_instr_in[30:21], 1'b0};
      default: in_imm32 = 32'h0;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;

    // Keep held operands current while execute stalls; harmless when empty.
    if (wb_write_in && (wb_addr_in != '0) && (wb_addr_in == rs1_q)) rs1_val_d = wb_data_in;
    if (wb_write_in && (wb_addr_in != '0) && (wb_addr_in == rs2_q)) rs2_val_d = wb_data_in;

    if (flush_in) begin
      valid_d = 1'b0;
    end else if (transfer) begin
      valid_d   = 1'b1;
      pc_d      = if_pc_in;
      opcode_d  = in_opcode;
      funct3_d  = if_instr_in[14:12];
      funct7_d  = if_instr_in[31:25];
      rd_d      = in_rd;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      rs1_val_d = in_rs1_val;
      rs2_val_d = in_rs2_val;
      imm_d     = XLEN'($signed(in_imm32));
    end else if (ex_ready_in) begin
      // Drained by execute, or a load-use bubble.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
    end
  end

  assign id_valid_out   = valid_q;
  assign id_pc_out      = pc_q;
  assign id_opcode_out  = opcode_q;
  assign id_funct3_out  = funct3_q;
  assign id_funct7_out  = funct7_q;
  assign id_rd_out      = rd_q;
  assign id_rs1_val_out = rs1_val_q;
  assign id_rs2_val_out = rs2_val_q;
  assign id_imm_out     = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid_in;
  logic [31:0] if_instr_in;
  logic [31:0] if_pc_in;
  logic        if_ready_out;
  logic [4:0]  rf_addr_a_out, rf_addr_b_out;
  logic [31:0] rf_a_in, rf_b_in;
  logic        wb_write_in;
  logic [4:0]  wb_addr_in;
  logic [31:0] wb_data_in;
  logic        flush_in;
  logic        ex_ready_in;
  logic        id_valid_out;
  logic [31:0] id_pc_out;
  logic [6:0]  id_opcode_out;
  logic [2:0]  id_funct3_out;
  logic [6:0]  id_funct7_out;
  logic [4:0]  id_rd_out;
  logic [31:0] id_rs1_val_out, id_rs2_val_out, id_imm_out;

  decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .if_valid_in(if_valid_in), .if_instr_in(if_instr_in), .if_pc_in(if_pc_in),
    .if_ready_out(if_ready_out),
    .rf_addr_a_out(rf_addr_a_out), .rf_addr_b_out(rf_addr_b_out),
    .rf_a_in(rf_a_in), .rf_b_in(rf_b_in),
    .wb_write_in(wb_write_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .flush_in(flush_in), .ex_ready_in(ex_ready_in),
    .id_valid_out(id_valid_out), .id_pc_out(id_pc_out), .id_opcode_out(id_opcode_out),
    .id_funct3_out(id_funct3_out), .id_funct7_out(id_funct7_out), .id_rd_out(id_rd_out),
    .id_rs1_val_out(id_rs1_val_out), .id_rs2_val_out(id_rs2_val_out), .id_imm_out(id_imm_out)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Register file model: combinational read, write at the rising edge.
  logic [31:0] regs [32];
  assign rf_a_in = regs[if_instr_in[19:15]];
  assign rf_b_in = regs[if_instr_in[24:20]];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0]  = 32'h0;
    regs[10] = 32'h0;
    regs[17] = 32'hACF2255B;
    forever begin
      @(posedge clk);
      if (wb_write_in && wb_addr_in != 5'd0) regs[wb_addr_in] <= wb_data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit uses_rs1(input logic [31:0] i);
    return !(i[6:0] == 7'h37 || i[6:0] == 7'h17 || i[6:0] == 7'h6F);
  endfunction

  function automatic bit uses_rs2(input logic [31:0] i);
    return (i[6:0] == 7'h33 || i[6:0] == 7'h23 || i[6:0] == 7'h63);
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] sx;
    sx = {32{i[31]}};
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return {sx[19:0], i[31:20]};
      7'h23:               return {sx[19:0], i[31:25], i[11:7]};
      7'h63:               return {sx[19:0], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17:        return i & 32'hFFFFF000;
      7'h6F:               return {sx[11:0], i[19:12], i[20], i[30:21], 1'b0};
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] opsel(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (wb_write_in && wb_addr_in == rs) return wb_data_in;
    return regs[rs];
  endfunction

  // Behavioural model of the held instruction.
  bit          m_known = 0;
  bit          m_rst   = 0;
  bit          m_valid = 0;
  logic [31:0] m_instr, m_pc, m_v1, m_v2;
  bit          m_hz, m_rdy;

  // Compare process: check the current state, then advance the model with
  // this cycle's inputs (stable until the next falling edge).
  always @(negedge clk) begin
    #2;
    if (m_known) begin
      m_hz = !flush_in && m_valid && m_instr[6:0] == 7'h03 && m_instr[11:7] != 5'd0 &&
             if_valid_in &&
             ((uses_rs1(if_instr_in) && if_instr_in[19:15] == m_instr[11:7]) ||
              (uses_rs2(if_instr_in) && if_instr_in[24:20] == m_instr[11:7]));
      m_rdy = (!m_valid || ex_ready_in) && !m_hz;
      chk("if_ready", {31'h0, if_ready_out}, {31'h0, m_rdy});
      chk("rf_addr_a", {27'h0, rf_addr_a_out}, {27'h0, if_instr_in[19:15]});
      chk("rf_addr_b", {27'h0, rf_addr_b_out}, {27'h0, if_instr_in[24:20]});
      chk("id_valid", {31'h0, id_valid_out}, {31'h0, m_valid});
      if (m_valid || m_rst) begin
        chk("id_pc", id_pc_out, m_pc);
        chk("id_opcode", {25'h0, id_opcode_out}, {25'h0, m_instr[6:0]});
        chk("id_funct3", {29'h0, id_funct3_out}, {29'h0, m_instr[14:12]});
        chk("id_funct7", {25'h0, id_funct7_out}, {25'h0, m_instr[31:25]});
        chk("id_rd", {27'h0, id_rd_out}, {27'h0, m_instr[11:7]});
        chk("id_rs1_val", id_rs1_val_out, m_v1);
        chk("id_rs2_val", id_rs2_val_out, m_v2);
        chk("id_imm", id_imm_out, ref_imm(m_instr));
      end
    end
    if (reset) begin
      m_valid = 0; m_instr = 0; m_pc = 0; m_v1 = 0; m_v2 = 0;
      m_rst = 1; m_known = 1;
    end else if (m_known) begin
      m_rst = 0;
      if (flush_in) begin
        m_valid = 0;
      end else if (if_valid_in && m_rdy) begin
        m_valid = 1;
        m_instr = if_instr_in;
        m_pc    = if_pc_in;
        m_v1    = opsel(if_instr_in[19:15]);
        m_v2    = opsel(if_instr_in[24:20]);
      end else if (ex_ready_in) begin
        m_valid = 0;
      end else begin
        if (wb_write_in && wb_addr_in != 5'd0 && wb_addr_in == m_instr[19:15]) m_v1 = wb_data_in;
        if (wb_write_in && wb_addr_in != 5'd0 && wb_addr_in == m_instr[24:20]) m_v2 = wb_data_in;
      end
    end
  end

  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic drive(input logic rst, input logic v, input logic [31:0] ins,
                       input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic fl, input logic exr);
    @(negedge clk);
    reset       = rst;
    if_valid_in = v;
    if_instr_in = ins;
    if_pc_in    = pc_ctr;
    pc_ctr      = pc_ctr + 32'd4;
    wb_write_in = wbw;
    wb_addr_in  = wba;
    wb_data_in  = wbd;
    flush_in    = fl;
    ex_ready_in = exr;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0]  ops [10];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h03};
    i = $urandom;
    if ($urandom_range(0, 15) != 0) i[6:0] = ops[$urandom_range(0, 9)];
    i[11:7]  = 5'($urandom_range(0, 4));
    i[19:15] = 5'($urandom_range(0, 4));
    i[24:20] = 5'($urandom_range(0, 4));
    return i;
  endfunction

  localparam logic [31:0] I_ADDI = 32'hFFF00293;
  localparam logic [31:0] I_ADD1 = 32'h011500B3;  // add x1,x10,x17
  localparam logic [31:0] I_LW   = 32'h0082A303;
  localparam logic [31:0] I_ADD7 = 32'h005303B3;
  localparam logic [31:0] I_SW   = 32'hFE512E23;
  localparam logic [31:0] I_LUI  = 32'h000012B7;
  localparam logic [31:0] I_JAL  = 32'h0100006F;
  localparam logic [31:0] I_BEQ  = 32'hFE000CE3;  // beq x0,x0,-8

  initial begin
    reset = 1; if_valid_in = 1; if_instr_in = I_ADDI; if_pc_in = 0;
    wb_write_in = 0; wb_addr_in = 0; wb_data_in = 0; flush_in = 0; ex_ready_in = 1;

    drive(1, 1, I_ADDI, 0, 0, 0, 0, 1);
    drive(1, 1, I_ADDI, 0, 0, 0, 0, 1);
    drive(0, 1, I_ADDI, 0, 0, 0, 0, 1);
    #3;
    chk("rst_valid", {31'h0, id_valid_out}, 32'h0);
    chk("rst_rd", {27'h0, id_rd_out}, 32'h0);
    chk("rst_imm", id_imm_out, 32'h0);
    chk("rst_pc", id_pc_out, 32'h0);

    drive(0, 1, I_ADD1, 1, 5'd10, 32'hFFFFFFAA, 0, 1);
    #3;
    chk("addi_valid", {31'h0, id_valid_out}, 32'h1);
    chk("addi_rd", {27'h0, id_rd_out}, 32'd5);
    chk("addi_imm", id_imm_out, 32'hFFFFFFFF);
    chk("addi_rs1", id_rs1_val_out, 32'h0);

    drive(0, 1, I_LW, 0, 0, 0, 0, 1);
    #3;
    chk("byp_rs1", id_rs1_val_out, 32'hFFFFFFAA);
    chk("byp_rs2", id_rs2_val_out, 32'hACF2255B);

    drive(0, 1, I_ADD7, 0, 0, 0, 0, 1);
    #3;
    chk("lu_ready0", {31'h0, if_ready_out}, 32'h0);
    chk("lu_lw_valid", {31'h0, id_valid_out}, 32'h1);
    chk("lu_lw_imm", id_imm_out, 32'd8);
    drive(0, 1, I_ADD7, 0, 0, 0, 0, 1);
    #3;
    chk("lu_bubble", {31'h0, id_valid_out}, 32'h0);
    chk("lu_ready1", {31'h0, if_ready_out}, 32'h1);

    drive(0, 1, I_ADDI, 0, 0, 0, 0, 0);
    #3;
    chk("lu_add_valid", {31'h0, id_valid_out}, 32'h1);
    chk("lu_add_rd", {27'h0, id_rd_out}, 32'd7);
    chk("hold_ready0", {31'h0, if_ready_out}, 32'h0);
    drive(0, 1, I_ADDI, 1, 5'd5, 32'hCCCCCCCC, 0, 0);
    #3;
    chk("hold_ready1", {31'h0, if_ready_out}, 32'h0);
    chk("hold_rd1", {27'h0, id_rd_out}, 32'd7);
    drive(0, 1, I_ADDI, 0, 0, 0, 0, 0);
    #3;
    chk("hold_ready2", {31'h0, if_ready_out}, 32'h0);
    chk("hold_rd2", {27'h0, id_rd_out}, 32'd7);
    chk("hold_refresh", id_rs2_val_out, 32'hCCCCCCCC);

    drive(0, 1, I_SW, 0, 0, 0, 1, 1);
    #3;
    chk("flush_ready", {31'h0, if_ready_out}, 32'h1);
    drive(0, 0, 32'h0, 0, 0, 0, 0, 1);
    #3;
    chk("flush_valid0", {31'h0, id_valid_out}, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 0, 0, 1);
    #3;
    chk("flush_valid1", {31'h0, id_valid_out}, 32'h0);

    drive(0, 1, I_SW, 0, 0, 0, 0, 1);
    drive(0, 1, I_LUI, 0, 0, 0, 0, 1);
    #3;
    chk("imm_s", id_imm_out, 32'hFFFFFFFC);
    drive(0, 1, I_JAL, 0, 0, 0, 0, 1);
    #3;
    chk("imm_u", id_imm_out, 32'h00001000);
    drive(0, 1, I_BEQ, 0, 0, 0, 0, 1);
    #3;
    chk("imm_j", id_imm_out, 32'h00000010);
    drive(0, 0, 32'h0, 0, 0, 0, 0, 1);
    #3;
    chk("imm_b", id_imm_out, 32'hFFFFFFF8);

    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            rand_instr(),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 4)),
            $urandom,
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
